// File: rtl/arb_pkg.sv
// Shared types and constants for the IFU/LSU memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;

  typedef enum logic {OWNER_IFU, OWNER_LSU} arb_owner_t;

  localparam int unsigned ARB_CNT_W = 4;

endpackage

// File: rtl/arb_rr_pick2.sv
// Two-way round-robin picker: on a tie, the requester that did not win last time is granted.
module arb_rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req_i,        // [0] = IFU, [1] = LSU
  input  arb_owner_t last_grant_i,
  output logic [1:0] gnt_o         // one-hot
);

  always_comb begin
    gnt_o = req_i;
    if (req_i[0] && req_i[1]) begin
      gnt_o = (last_grant_i == OWNER_IFU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between IFU and LSU, one access in flight.
// Define ARB_LSU_PRIORITY_EN for fixed LSU priority instead of round-robin arbitration.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH   = 30,
  parameter int unsigned BUSWIDTH    = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 cpu_rst,

  input  logic                 ifu_req_valid,
  output logic                 ifu_req_ready,
  input  logic [ADDRWIDTH-1:0] ifu_req_addr,
  output logic                 ifu_rsp_valid,
  output logic [BUSWIDTH-1:0]  ifu_rsp_data,

  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic [ADDRWIDTH-1:0] lsu_req_addr,
  input  logic [BUSWIDTH-1:0]  lsu_req_wdata,
  input  logic [3:0]           lsu_req_strobe,
  output logic                 lsu_rsp_valid,
  output logic [BUSWIDTH-1:0]  lsu_rsp_data,

  output logic                 mem_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [BUSWIDTH-1:0]  mem_wr_data,
  output logic [3:0]           mem_wr_strobe,
  input  logic [BUSWIDTH-1:0]  mem_rd_data
);

  arb_state_t             state_q, state_d;
  arb_owner_t             owner_q, owner_d;
  logic [ARB_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [BUSWIDTH-1:0]    wdata_q, wdata_d;
  logic [3:0]             strobe_q, strobe_d;
  logic [1:0]             grant;
  logic                   handshake;

`ifdef ARB_LSU_PRIORITY_EN
  assign grant = lsu_req_valid ? 2'b10 : {1'b0, ifu_req_valid};
`else
  arb_owner_t last_grant_q, last_grant_d;

  arb_rr_pick2 u_pick (
    .req_i        ({lsu_req_valid, ifu_req_valid}),
    .last_grant_i (last_grant_q),
    .gnt_o        (grant)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    if (handshake) begin
      last_grant_d = owner_d;
    end
  end

  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      last_grant_q <= OWNER_IFU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign handshake = ifu_req_ready | lsu_req_ready;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strobe_d      = strobe_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    mem_en        = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // Readies are masked while reset is held so every output reads 0 during reset.
        ifu_req_ready = grant[0] & ~cpu_rst;
        lsu_req_ready = grant[1] & ~cpu_rst;
        if (lsu_req_ready) begin
          owner_d  = OWNER_LSU;
          addr_d   = lsu_req_addr;
          wdata_d  = lsu_req_wdata;
          strobe_d = lsu_req_strobe;
          state_d  = ARB_ISSUE;
        end else if (ifu_req_ready) begin
          owner_d  = OWNER_IFU;
          addr_d   = ifu_req_addr;
          wdata_d  = '0;
          strobe_d = '0;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_en  = 1'b1;
        cnt_d   = ARB_CNT_W'(MEM_LATENCY);
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ifu_rsp_valid = (owner_q == OWNER_IFU);
          lsu_rsp_valid = (owner_q == OWNER_LSU);
          state_d       = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_IFU;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_wr_data   = wdata_q;
  assign mem_wr_strobe = strobe_q;

  // Stores acknowledge with zero data; reads pass the memory output straight through.
  assign ifu_rsp_data = ifu_rsp_valid ? mem_rd_data : '0;
  assign lsu_rsp_data = (lsu_rsp_valid && (strobe_q == 4'b0000)) ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a timeline model of accesses.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 3;

  logic        clk;
  logic        cpu_rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [29:0] ifu_req_addr;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic [29:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata, lsu_rsp_data;
  logic [3:0]  lsu_req_strobe;
  logic        mem_en;
  logic [29:0] mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
  logic [3:0]  mem_wr_strobe;

  int checks;
  int failures;

  // Model: an access is described by its handshake cycle; everything else is arithmetic on it.
  int          cyc;
  bit          m_busy;
  int          m_hs;
  bit          m_own_lsu;
  bit          m_last_lsu;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strobe;

  mem_port_arbiter #(
    .ADDRWIDTH   (30),
    .BUSWIDTH    (32),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .cpu_rst        (cpu_rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_data   (ifu_rsp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_strobe (lsu_req_strobe),
    .lsu_rsp_valid  (lsu_rsp_valid),
    .lsu_rsp_data   (lsu_rsp_data),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_strobe  (mem_wr_strobe),
    .mem_rd_data    (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_last_lsu = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_strobe   = '0;
  endtask

  task automatic chk_all_zero();
    chk("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
    chk("rst_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
    chk("rst_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
    chk("rst_ifu_data", ifu_rsp_data, 32'd0);
    chk("rst_lsu_data", lsu_rsp_data, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wr_data, 32'd0);
    chk("rst_mem_strobe", 32'(mem_wr_strobe), 32'd0);
  endtask

  // Called at a falling edge with inputs already set; checks, clocks once, retires grants.
  task automatic cycle();
    bit          e_gi, e_gl, e_en, e_ri, e_rl;
    logic [31:0] e_di, e_dl;
    #1;
    if (m_busy && cyc >= m_hs + int'(LAT) + 2) m_busy = 1'b0;
    e_gi = 1'b0;
    e_gl = 1'b0;
    if (!m_busy) begin
      if (ifu_req_valid && lsu_req_valid) begin
`ifdef ARB_LSU_PRIORITY_EN
        e_gl = 1'b1;
`else
        if (m_last_lsu) e_gi = 1'b1;
        else            e_gl = 1'b1;
`endif
      end else begin
        e_gi = ifu_req_valid;
        e_gl = lsu_req_valid;
      end
    end
    e_en = m_busy && (cyc == m_hs + 1);
    e_ri = m_busy && !m_own_lsu && (cyc == m_hs + 1 + int'(LAT));
    e_rl = m_busy && m_own_lsu && (cyc == m_hs + 1 + int'(LAT));
    e_di = e_ri ? mem_rd_data : 32'd0;
    e_dl = (e_rl && m_strobe == 4'd0) ? mem_rd_data : 32'd0;
    chk("ifu_ready", 32'(ifu_req_ready), 32'(e_gi));
    chk("lsu_ready", 32'(lsu_req_ready), 32'(e_gl));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(e_ri));
    chk("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(e_rl));
    chk("ifu_rsp_data", ifu_rsp_data, e_di);
    chk("lsu_rsp_data", lsu_rsp_data, e_dl);
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wr_data", mem_wr_data, m_wdata);
    chk("mem_wr_strobe", 32'(mem_wr_strobe), 32'(m_strobe));
    @(posedge clk);
    if (e_gi || e_gl) begin
      m_busy     = 1'b1;
      m_hs       = cyc;
      m_own_lsu  = e_gl;
      m_last_lsu = e_gl;
      m_addr     = e_gl ? lsu_req_addr : ifu_req_addr;
      m_wdata    = e_gl ? lsu_req_wdata : 32'd0;
      m_strobe   = e_gl ? lsu_req_strobe : 4'd0;
    end
    cyc++;
    @(negedge clk);
    if (e_gi) ifu_req_valid = 1'b0;
    if (e_gl) lsu_req_valid = 1'b0;
  endtask

  // Async reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    cpu_rst = 1'b1;
    #1;
    chk_all_zero();
    @(posedge clk);
    @(negedge clk);
    cpu_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    cpu_rst        = 1'b1;
    ifu_req_valid  = 1'b1;
    lsu_req_valid  = 1'b1;
    ifu_req_addr   = 30'h5;
    lsu_req_addr   = 30'h6;
    lsu_req_wdata  = 32'h0;
    lsu_req_strobe = 4'h0;
    mem_rd_data    = 32'hA5A5_A5A5;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    cpu_rst       = 1'b0;

    // IFU-only read of 0x10 returning 0xDEADBEEF.
    mem_rd_data   = 32'hDEAD_BEEF;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 30'h10;
    repeat (LAT + 3) cycle();

    // LSU store; data pulse must read back as 0.
    lsu_req_valid  = 1'b1;
    lsu_req_addr   = 30'h20;
    lsu_req_wdata  = 32'h1234_5678;
    lsu_req_strobe = 4'b0011;
    repeat (LAT + 3) cycle();

    // LSU raised while an IFU access is in ISSUE.
    ifu_req_valid  = 1'b1;
    ifu_req_addr   = 30'h44;
    cycle();
    lsu_req_valid  = 1'b1;
    lsu_req_addr   = 30'h48;
    lsu_req_strobe = 4'b0000;
    repeat (2 * LAT + 5) cycle();

    // Reset during WAIT: pending response dropped, then first tie goes to LSU.
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 30'h77;
    repeat (3) cycle();
    do_reset();
    for (int i = 0; i < 4 * (int'(LAT) + 2); i++) begin
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      ifu_req_addr  = 30'h100 + 30'(i);
      lsu_req_addr  = 30'h200 + 30'(i);
      mem_rd_data   = $urandom();
      cycle();
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    repeat (LAT + 2) cycle();

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (!ifu_req_valid && ($urandom_range(2) == 0)) begin
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 30'($urandom());
      end
      if (!lsu_req_valid && ($urandom_range(2) == 0)) begin
        lsu_req_valid  = 1'b1;
        lsu_req_addr   = 30'($urandom());
        lsu_req_wdata  = $urandom();
        lsu_req_strobe = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
      end
      mem_rd_data = $urandom();
      if (i == 200) do_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the core. Each requester uses a valid/ready request handshake and receives a one-cycle response pulse. The block allows one outstanding access, inserts the memory's fixed read latency, and arbitrates simultaneous requests round-robin. It sits between the core's instr/data master interfaces and the unified behavioural RAM.

## Interface
- ADDRWIDTH, 30: word address width.
- BUSWIDTH, 32: data width.
- MEM_LATENCY, 1: cycles from the memory sampling `mem_en` to `mem_rd_data` being valid; legal range 1..15.
- clk  in  1  sole clock; all flops rise-edge.
- cpu_rst  in  1  reset, asynchronous and active-high.
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_req_addr  in  ADDRWIDTH  fetch word address.
- ifu_rsp_valid  out  1  one-cycle fetch data pulse.
- ifu_rsp_data  out  BUSWIDTH  fetch data.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  load/store request accepted this cycle.
- lsu_req_addr  in  ADDRWIDTH  data word address.
- lsu_req_wdata  in  BUSWIDTH  store data.
- lsu_req_strobe  in  4  byte enables; non-zero means write, zero means read.
- lsu_rsp_valid  out  1  one-cycle load data pulse or store acknowledge.
- lsu_rsp_data  out  BUSWIDTH  load data; 0 for stores.
- mem_en  out  1  access strobe, one cycle per access.
- mem_addr  out  ADDRWIDTH  registered address.
- mem_wr_data  out  BUSWIDTH  registered write data.
- mem_wr_strobe  out  4  registered byte enables; 0 for IFU and for reads.
- mem_rd_data  in  BUSWIDTH  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - Arbitration is combinational.
  - Only IFU valid: grant IFU. Only LSU valid: grant LSU.
  - Both valid: grant the requester not in `last_grant`.
  - `*_req_ready` = (state==IDLE) & grant for that requester. At most one ready is high in any cycle.
  - On a handshake, register the address, wdata, strobe (forced to 0 for IFU) and the owner; update `last_grant`; go to ISSUE.
- **ISSUE**
  - `mem_en` = 1 for exactly one cycle.
  - Load `cnt` with MEM_LATENCY; go to WAIT.
- **WAIT**
  - `cnt` decrements each cycle.
  - When `cnt`==1, assert the owner's `rsp_valid` and go to IDLE.
  - Response data passes combinationally from `mem_rd_data`. For an LSU write, `lsu_rsp_data` = 0.
- `mem_addr`, `mem_wr_data` and `mem_wr_strobe` hold their values from ISSUE through the end of WAIT.
- Requesters keep valid and payload stable until ready. The arbiter does not check this; a dropped valid before ready is simply never granted.
- A request that arrives during ISSUE or WAIT waits. It is arbitrated in the next IDLE cycle.
- A non-owner's `rsp_valid` is never asserted.
- `*_rsp_data` is 0 whenever the matching `rsp_valid` is 0.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = IFU, `cnt` = 0.
  - All outputs 0: both `req_ready`, both `rsp_valid`, both `rsp_data`, `mem_en`, `mem_addr`, `mem_wr_data`, `mem_wr_strobe`.
  - Exception: a ready may rise combinationally in the first IDLE cycle after reset deassertion.
- First tie after reset goes to LSU.
- Handshake in cycle T:
  - `mem_en` = 1 in T+1.
  - `rsp_valid` in T+1+MEM_LATENCY.
  - IDLE again in T+2+MEM_LATENCY.
- Throughput is one access per MEM_LATENCY+2 cycles. There is no back-to-back acceptance.
- Reset mid-access (any state): return to IDLE immediately. The pending response is discarded and never pulsed. `mem_en` drops asynchronously.
- A response and a new request in the same cycle: the new request waits one cycle, because the response cycle is WAIT, not IDLE.

## Configuration
- `ARB_LSU_PRIORITY_EN` defined:
  - Fixed priority. LSU always wins a tie.
  - `last_grant` flop and the round-robin picker are removed.
- Not defined: round-robin as described in Operation.

## Structure
- Shared package `arb_pkg` holds:
  - `arb_state_t` {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
  - `arb_owner_t` {OWNER_IFU, OWNER_LSU}
  - `ARB_CNT_W` = 4
- Sub-module `arb_rr_pick2`: 2-way round-robin picker. Inputs: two requests and `last_grant`. Output: one-hot grant. Compiled out under `ARB_LSU_PRIORITY_EN`.
- The FSM, counter, payload registers and response steering live in the top.

## Test plan
- IFU-only read, MEM_LATENCY=1, addr 0x10, memory returns 0xDEADBEEF:
  - `mem_en` at T+1 with `mem_addr`=0x10, `mem_wr_strobe`=0.
  - `ifu_rsp_valid` at T+2 with data 0xDEADBEEF; `lsu_rsp_valid` stays 0.
- LSU store, addr 0x20, wdata 0x12345678, strobe 4'b0011:
  - `mem_wr_strobe`=0011 and `mem_wr_data`=0x12345678 at T+1.
  - `lsu_rsp_valid` at T+2 with data 0.
- Both requesters continuously valid from reset, round-robin:
  - Grants alternate LSU, IFU, LSU, IFU.
  - Handshakes are 3 cycles apart.
  - With `ARB_LSU_PRIORITY_EN`: all grants go to LSU.
- MEM_LATENCY=3, IFU read at T:
  - `rsp_valid` at T+4 only.
  - `mem_addr` held T+1..T+4.
  - The next ready is no earlier than T+5.
- `cpu_rst` pulsed during WAIT:
  - All outputs are 0 during reset.
  - No `rsp_valid` follows.
  - The first tie after release goes to LSU.
- LSU request raised during ISSUE of an IFU access:
  - `lsu_req_ready` stays low until the IFU response completes.
  - It is granted in the next IDLE cycle.
